// File: rtl/div_fsm_pkg.sv
// Shared divider definitions: state encoding, default sizes and result field offsets.
// Field offsets match mul_fsm so FIFO_out decode logic can be shared.
package div_fsm_pkg;

    localparam int DIV_DATA_SIZE_D = 8;
    localparam int DATA_SIZE_D     = 2 * DIV_DATA_SIZE_D;
    localparam int ID_SIZE_D       = 8;

    localparam int Q_LSB   = 0;
    localparam int R_LSB   = DIV_DATA_SIZE_D;
    localparam int ERR_BIT = DATA_SIZE_D;
    localparam int ID_LSB  = DATA_SIZE_D + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_SAVE  = 3'd4
    } div_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/div_fsm_sub_step.sv
// One restoring-division trial subtract: diff = A - M over N+1 bits,
// with no_borrow set when the partial remainder can absorb the divisor.
module div_sub_step #(
    parameter int N = 8
) (
    input  logic [N:0]   i_a,
    input  logic [N-1:0] i_m,
    output logic [N:0]   o_diff,
    output logic         o_no_borrow
);

    logic [N+1:0] w_full;

    // One guard bit above A so the borrow out is visible as the sign
    assign w_full      = {1'b0, i_a} - {2'b00, i_m};
    assign o_diff      = w_full[N:0];
    assign o_no_borrow = ~w_full[N+1];

endmodule

// File: rtl/div_fsm.sv
// Sequential restoring divider: pops (a/b, id), iterates shift/subtract N times,
// and presents {id, err, remainder, quotient} until FIFO_out stores it.
module div_fsm
    import div_fsm_pkg::*;
#(
    parameter int DATA_SIZE     = DATA_SIZE_D,
    parameter int DIV_DATA_SIZE = DATA_SIZE / 2,
    parameter int ID_SIZE       = ID_SIZE_D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DIV_DATA_SIZE-1:0]     a_in,
    input  logic [DIV_DATA_SIZE-1:0]     b_in,
    input  logic [ID_SIZE-1:0]           id_div,
    input  logic                         d_valid_data,
    input  logic                         ready_f_res,
    input  logic                         div_written,
    output logic                         d_ready_data,
    output logic                         d_valid_res,
    output logic [DATA_SIZE+ID_SIZE:0]   result_div
);

    localparam int N  = DIV_DATA_SIZE;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e       r_state;
    logic [N-1:0]     r_m;
    logic [N-1:0]     r_q;
    logic [N:0]       r_a;
    logic [ID_SIZE-1:0] r_id;
    logic             r_err;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

    logic [N:0]       w_diff;
    logic             w_no_borrow;

    div_sub_step #(
        .N(N)
    ) u_sub (
        .i_a        (r_a),
        .i_m        (r_m),
        .o_diff     (w_diff),
        .o_no_borrow(w_no_borrow)
    );

    assign d_ready_data = (r_state == S_IDLE) & ready_f_res;
    assign d_valid_res  = r_valid;
    assign result_div   = {r_id, r_err, r_a[N-1:0], r_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_a     <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (d_valid_data && ready_f_res) begin
                        r_m     <= b_in;
                        r_q     <= a_in;
                        r_a     <= '0;
                        r_id    <= id_div;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Divide by zero: remainder = dividend, quotient = all ones
                    if (r_m == '0) begin
                        r_err   <= 1'b1;
                        r_a     <= {1'b0, r_q};
                        r_q     <= '1;
                        r_valid <= 1'b1;
                        r_state <= S_SAVE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {r_a, r_q} <= {r_a[N-1:0], r_q, 1'b0};
                    r_state    <= S_SUB;
                end
                S_SUB: begin
                    if (w_no_borrow) begin
                        r_a    <= w_diff;
                        r_q[0] <= 1'b1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_valid <= 1'b1;
                        r_state <= S_SAVE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SAVE: begin
                    if (div_written) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
